// File: rtl/q1_seq_pkg.sv
// Shared types, sizes and golden full-adder model for the q1 transition sequencer.
package q1_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY_FROM,
        ST_APPLY_TO,
        ST_REPORT,
        ST_DONE
    } state_e;

    typedef enum logic {
        MODE_TABLE = 1'b0,
        MODE_TRANS = 1'b1
    } mode_e;

    localparam int unsigned N_VEC   = 8;
    localparam int unsigned N_PAIRS = 56;

    // Returns {carry, sum} for v = {a,b,c}.
    function automatic logic [1:0] q1_golden(input logic [2:0] v);
        return {(v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]), ^v};
    endfunction

endpackage

// File: rtl/q1_transition_sequencer_dwell_timer.sv
// Loadable dwell down-counter; expire is high on the last cycle of a dwell.
module q1_dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/q1_transition_sequencer.sv
// Stimulus sequencer for the q1 full-adder gate: truth-table or all-transition sweeps.
// Optional golden-model checking is enabled with the Q1_SEQ_CHECK_EN macro.
module q1_transition_sequencer
    import q1_seq_pkg::*;
#(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y0,
    input  logic       y1,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_from,
    output logic [2:0] res_to,
    output logic [1:0] res_y,
    output logic       res_mismatch,
    output logic [6:0] err_count,
    output logic       busy,
    output logic       done
);

    state_e     state, state_nxt;
    mode_e      mode_q;
    logic [2:0] from_q, to_q;
    logic [5:0] step_q;
    logic       load, expire, last, accept, sample, go;

    assign go     = (state == ST_IDLE) && start;
    assign accept = (state == ST_REPORT) && res_ready && !abort;
    assign sample = (state == ST_APPLY_TO) && expire && !abort;
    assign last   = (mode_q == MODE_TRANS) ? (step_q == 6'(N_PAIRS - 1))
                                           : (step_q == 6'(N_VEC - 1));

    q1_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(DWELL_W'(DWELL - 1)),
        .expire  (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nxt = mode ? ST_APPLY_FROM : ST_APPLY_TO;
                load      = 1'b1;
            end
            ST_APPLY_FROM: if (expire) begin
                state_nxt = ST_APPLY_TO;
                load      = 1'b1;
            end
            ST_APPLY_TO: if (expire) state_nxt = ST_REPORT;
            ST_REPORT: if (res_ready) begin
                if (last) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = (mode_q == MODE_TRANS) ? ST_APPLY_FROM : ST_APPLY_TO;
                    load      = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything outside IDLE, where start has priority.
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
        end
    end

    always_comb begin
        {a, b, c} = 3'b000;
        res_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_APPLY_FROM: begin {a, b, c} = from_q; busy = 1'b1; end
            ST_APPLY_TO:   begin {a, b, c} = to_q;   busy = 1'b1; end
            ST_REPORT:     begin {a, b, c} = to_q;   busy = 1'b1; res_valid = 1'b1; end
            ST_DONE:       done = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_TABLE;
            from_q   <= '0;
            to_q     <= '0;
            step_q   <= '0;
            res_from <= '0;
            res_to   <= '0;
            res_y    <= '0;
        end else begin
            if (go) begin
                mode_q <= mode_e'(mode);
                from_q <= '0;
                to_q   <= mode ? 3'd1 : 3'd0;
                step_q <= '0;
            end else if (accept) begin
                step_q <= step_q + 1'b1;
                // Transition order skips the diagonal; to wraps into the next from row.
                if (mode_q == MODE_TABLE)
                    to_q <= to_q + 1'b1;
                else if (to_q == 3'd7) begin
                    from_q <= from_q + 1'b1;
                    to_q   <= '0;
                end else if (to_q + 3'd1 == from_q)
                    to_q <= to_q + 3'd2;
                else
                    to_q <= to_q + 1'b1;
            end
            if (sample) begin
                res_from <= (mode_q == MODE_TRANS) ? from_q : to_q;
                res_to   <= to_q;
                res_y    <= {y1, y0};
            end
        end
    end

`ifdef Q1_SEQ_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_mismatch <= 1'b0;
            err_count    <= '0;
        end else begin
            if (sample)
                res_mismatch <= ({y1, y0} != q1_golden(to_q));
            if (go)
                err_count <= '0;
            else if (accept && res_mismatch && err_count != 7'h7f)
                err_count <= err_count + 1'b1;
        end
    end
`else
    assign res_mismatch = 1'b0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_q1_transition_sequencer.sv
// Scoreboard bench for q1_transition_sequencer with a behavioural q1 full adder.
module tb_q1_transition_sequencer;

    typedef struct packed {
        logic [2:0] from;
        logic [2:0] to;
        logic [1:0] y;
        logic       mm;
    } exp_t;

`ifdef Q1_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // {carry,sum} for vectors 0..7
    localparam logic [1:0] EXP_Y [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0, res_ready = 1'b1;
    logic a, b, c, y0, y1, res_valid, res_mismatch, busy, done;
    logic [2:0] res_from, res_to;
    logic [1:0] res_y;
    logic [6:0] err_count;
    logic force_y1_zero = 1'b0;

    int n_cmp = 0, n_bad = 0, n_acc = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    assign y0 = a ^ b ^ c;
    assign y1 = force_y1_zero ? 1'b0 : ((a & b) | (a & c) | (b & c));

    q1_transition_sequencer #(.DWELL(4), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .a(a), .b(b), .c(c), .y0(y0), .y1(y1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_from(res_from), .res_to(res_to), .res_y(res_y),
        .res_mismatch(res_mismatch), .err_count(err_count),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is matched against the head of the queue.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", {res_from, res_to}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_from", res_from, e.from);
                chk("res_to", res_to, e.to);
                chk("res_y", res_y, e.y);
                chk("res_mismatch", res_mismatch, e.mm);
            end
            n_acc++;
        end
    end

    task automatic push_table(input bit y1_zero);
        exp_t e;
        for (int v = 0; v < 8; v++) begin
            e.from = 3'(v);
            e.to   = 3'(v);
            e.y    = y1_zero ? {1'b0, EXP_Y[v][0]} : EXP_Y[v];
            e.mm   = y1_zero & CHK & EXP_Y[v][1];
            q.push_back(e);
        end
    endtask

    task automatic push_trans(input int max_pairs);
        exp_t e;
        int   k = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i != j && k < max_pairs) begin
                    e.from = 3'(i);
                    e.to   = 3'(j);
                    e.y    = EXP_Y[j];
                    e.mm   = 1'b0;
                    q.push_back(e);
                    k++;
                end
    endtask

    task automatic kick(input logic m);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic m, input bit stall, input int exp_first,
                             input int exp_total, input logic [6:0] exp_err);
        int n = 0, first = -1, left = 0;
        logic [9:0] held = '0;
        bit stalled = 1'b0;
        kick(m);
        chk("busy_after_start", busy, 1);
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (res_valid && first < 0) first = n;
            if (done) break;
            if (stall && !stalled && res_valid && res_to == 3'd2) begin
                stalled   = 1'b1;
                res_ready = 1'b0;
                left      = 10;
                held      = {res_from, res_to, res_y, res_mismatch, res_valid};
            end else if (left > 0) begin
                chk("stall_fields", {res_from, res_to, res_y, res_mismatch, res_valid}, held);
                chk("stall_abc", {a, b, c}, 3'b010);
                left--;
                if (left == 0) res_ready = 1'b1;
            end
        end
        chk("done_seen", done, 1);
        chk("first_valid_cycle", first, exp_first);
        chk("sweep_cycles", n, exp_total);
        chk("busy_during_done", busy, 0);
        chk("err_count", err_count, exp_err);
        chk("queue_drained", q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int n;
        int dones;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {a, b, c, res_valid, res_from, res_to, res_y, res_mismatch,
                              err_count, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_abc", {a, b, c, busy}, 0);

        // Table sweep, correct gate
        push_table(1'b0);
        run_sweep(1'b0, 1'b0, 4, 40, 7'd0);

        // Table sweep with 10-cycle backpressure on the third result
        push_table(1'b0);
        run_sweep(1'b0, 1'b1, 4, 50, 7'd0);

        // Abort during APPLY_FROM of pair 20 (2 -> 7)
        push_trans(20);
        n = 0;
        kick(1'b1);
        while (n_acc % 1000 != 0 && n < 0) n++;
        begin
            int base = n_acc - 1;
            base = n_acc - 0;
            n = 0;
            while (n_acc < base + 20 && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("abort_reach_pair20", n_acc - base, 20);
        end
        chk("pair20_from_abc", {a, b, c}, 3'b010);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {busy, res_valid, a, b, c}, 0);
        chk("abort_err_kept", err_count, 0);
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_queue", q.size(), 0);

        // Full transition sweep restarts at (000,001)
        push_trans(56);
        run_sweep(1'b1, 1'b0, 8, 504, 7'd0);

        // Asynchronous reset while holding REPORT
        res_ready = 1'b0;
        kick(1'b0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("report_reached", res_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {a, b, c, res_valid, res_from, res_to, res_y, res_mismatch,
                                    err_count, busy, done}, 0);
        #3 rst = 1'b0;
        res_ready = 1'b1;

        // Table sweep with carry stuck at 0
        force_y1_zero = 1'b1;
        push_table(1'b1);
        run_sweep(1'b0, 1'b0, 4, 40, CHK ? 7'd4 : 7'd0);
        force_y1_zero = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/q1_transition_sequencer.md
# q1_transition_sequencer

Self-running stimulus controller for the q1 full-adder gate (`y0` = sum, `y1` = carry). It drives the gate's `a`/`b`/`c` inputs through either the 8-entry truth table or all 56 ordered input transitions. Each vector is held for a programmable dwell, the gate outputs are sampled, and one result per step is reported over a valid/ready port. It sits between a host or bench controller and the q1 instance, so exhaustive gate checks run without hand-written stimulus lists.

## Interface
- `DWELL`, 4: cycles each applied vector is held; must be ≥1.
- `DWELL_W`, 8: width of the dwell counter; `DWELL` < 2^`DWELL_W`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `mode` in 1: 0 = truth table, 1 = all transitions; captured at start.
- `abort` in 1: cancel the sweep in progress.
- `a`, `b`, `c` out 1 each: stimulus to q1.
- `y0`, `y1` in 1 each: q1 outputs.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_from` out 3: from-vector {a,b,c}; equals `res_to` in table mode.
- `res_to` out 3: vector applied when the sample was taken.
- `res_y` out 2: sampled {y1,y0}.
- `res_mismatch` out 1: result differs from the golden model (see Configuration).
- `err_count` out 7: mismatches in the current or last sweep.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at normal sweep completion.

## Operation
- FSM states: IDLE, APPLY_FROM, APPLY_TO, REPORT, DONE.
- IDLE: `a`/`b`/`c` = 000.
  - On `start`, capture `mode`, clear indices and `err_count`.
  - Go to APPLY_TO in table mode, APPLY_FROM in transition mode.
- APPLY_FROM: drive the from-vector for `DWELL` cycles, then go to APPLY_TO.
- APPLY_TO: drive the to-vector for `DWELL` cycles.
  - On the edge ending the last dwell cycle, register {y1,y0}; go to REPORT.
- REPORT: `res_valid`=1, all result fields stable, `a`/`b`/`c` held at the to-vector until `res_valid`&&`res_ready`.
  - On handshake, advance the indices. If that was the last step, go to DONE; otherwise return to APPLY_FROM or APPLY_TO.
- DONE: `done`=1 for one cycle, then IDLE.
- Table order: vector 0..7, 8 results.
- Transition order: from i = 0..7 (outer), to j = 0..7 (inner), skipping j==i; 56 results. The first result is (000→001), the last is (111→110).
- `start` while `busy` is ignored.
- `abort` in any non-IDLE state:
  - IDLE on the next edge, `a`/`b`/`c`=000.
  - `res_valid` drops even mid-handshake; no `done` pulse.
  - `err_count` retains its value.
- `abort` and `start` together in IDLE: `start` wins.

## Timing
- Reset values: `a`,`b`,`c`,`res_valid`,`res_from`,`res_to`,`res_y`,`res_mismatch`,`err_count`,`busy`,`done` all 0; state IDLE.
- Reset mid-sweep: same values immediately (asynchronous), no `done`.
- `busy` goes high on the edge that samples `start`. It stays high through REPORT, falls on the edge entering DONE, and is low while `done` is high.
- Step period with `res_ready` tied 1:
  - Table mode: `DWELL`+1 cycles.
  - Transition mode: 2·`DWELL`+1 cycles.
- Full sweep with `DWELL`=4 and `res_ready`=1: table = 40 cycles from the `start` edge to the DONE entry; transitions = 504.
- First `res_valid` asserts `DWELL` edges after the `start` edge (table mode).
- Backpressure only stretches REPORT; dwell timing is unaffected.

## Configuration
- `Q1_SEQ_CHECK_EN` defined:
  - Golden model: y0 = a^b^c, y1 = majority(a,b,c).
  - `res_mismatch` is registered with `res_y` against `res_to`.
  - `err_count` increments by 1 per accepted mismatching result; it saturates at 127 and clears on `start`.
- Not defined: `res_mismatch` and `err_count` are tied 0 and no comparator logic is built. The ports remain, so the interface is identical.

## Structure
- Package `q1_seq_pkg` holds:
  - the state enum and mode enum;
  - localparams `N_VEC`=8 and `N_PAIRS`=56;
  - the golden-model function used under `Q1_SEQ_CHECK_EN`.
- Sub-module `q1_dwell_timer`: loadable down-counter of width `DWELL_W`. It pulses `expire` on the last dwell cycle and reloads on `load`.

## Test plan
- Table mode, `DWELL`=4, `res_ready`=1, correct q1 → 8 results with to = 0..7 and `res_y` = 00,01,01,10,01,10,10,11. `done` pulses once; 40 cycles from start; `err_count`=0.
- Transition mode, `res_ready`=1 → 56 results, first (000,001,y=01), last (111,110,y=10). No pair with from==to appears.
- `res_ready` held low 10 cycles on the third table result → `res_valid` and fields stable, `a`/`b`/`c`=010 held, no result skipped or duplicated.
- `abort` asserted during APPLY_FROM of pair 20 → next cycle IDLE, `busy`=0, `a`/`b`/`c`=000, no `done`. A new `start` restarts at (000,001).
- Async `rst` mid-REPORT → all outputs 0 immediately. With `Q1_SEQ_CHECK_EN` and y1 forced 0, a table sweep gives `err_count`=4 with `res_mismatch` set on vectors 3,5,6,7.
